// File: rtl/mem_port_arbiter_if.sv
// Bundle of the four pipeline memory ports, the shared main-memory bus and arbiter status.
// The master modport is the arbiter's view; slave is the view of whatever surrounds it.
interface mem_port_arbiter_if #(
  parameter int DATAW = 32,
  parameter int ADDRW = 32,
  parameter int SIZEW = 4
);
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [4*ADDRW-1:0] req_address;
  logic [3:0]         req_wr_en;
  logic [4*DATAW-1:0] req_wr_data;
  logic [4*SIZEW-1:0] req_wr_size;
  logic [3:0]         req_dp_valid;
  logic [3:0]         req_dp_ready;
  logic [DATAW-1:0]   req_dp_read_data;

  logic               bus_valid;
  logic               bus_ready;
  logic [ADDRW-1:0]   bus_address;
  logic               bus_wr_en;
  logic [DATAW-1:0]   bus_wr_data;
  logic [SIZEW-1:0]   bus_wr_size;
  logic               bus_dp_valid;
  logic               bus_dp_ready;
  logic [DATAW-1:0]   bus_dp_read_data;

  logic [1:0]         grant_id;
  logic               busy;
  logic               timeout_err;

  modport master (
    input  req_valid, req_address, req_wr_en, req_wr_data, req_wr_size, req_dp_ready,
    input  bus_ready, bus_dp_valid, bus_dp_read_data,
    output req_ready, req_dp_valid, req_dp_read_data,
    output bus_valid, bus_address, bus_wr_en, bus_wr_data, bus_wr_size, bus_dp_ready,
    output grant_id, busy, timeout_err
  );

  modport slave (
    output req_valid, req_address, req_wr_en, req_wr_data, req_wr_size, req_dp_ready,
    output bus_ready, bus_dp_valid, bus_dp_read_data,
    input  req_ready, req_dp_valid, req_dp_read_data,
    input  bus_valid, bus_address, bus_wr_en, bus_wr_data, bus_wr_size, bus_dp_ready,
    input  grant_id, busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing the main-memory bus between emem, rmem, wmem and imem.
// emem always wins; the other three rotate, and a silent bus is cut off after TOUT cycles.
module mem_port_arbiter #(
  parameter int DATAW = 32,
  parameter int ADDRW = 32,
  parameter int SIZEW = 4,
  parameter int TOUT  = 255
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master arb
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [7:0] TOUT_C = 8'(TOUT);

  state_t           state_q;
  logic [1:0]       rr_ptr_q;
  logic [1:0]       grant_id_q;
  logic [7:0]       tcnt_q;
  logic             timeout_err_q;
  logic             bus_valid_q;
  logic             bus_wr_en_q;
  logic [ADDRW-1:0] bus_address_q;
  logic [DATAW-1:0] bus_wr_data_q;
  logic [SIZEW-1:0] bus_wr_size_q;

  logic             win_valid;
  logic [1:0]       win_id;
  logic             in_resp;
  logic             resp_tmo;

  // Search the rotating ports from the farthest to the nearest so the port at rr_ptr ends up winning.
  always_comb begin
    int cand;
    win_valid = 1'b0;
    win_id    = 2'd0;
    cand      = 0;
    for (int k = 2; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand > 3) cand = cand - 3;
      if (arb.req_valid[cand]) begin
        win_valid = 1'b1;
        win_id    = 2'(cand);
      end
    end
    if (arb.req_valid[0]) begin
      win_valid = 1'b1;
      win_id    = 2'd0;
    end
  end

  assign in_resp  = (state_q == RESP);
  // A response arriving in the same cycle as the limit takes precedence over the forced one.
  assign resp_tmo = in_resp && (tcnt_q == TOUT_C) && !arb.bus_dp_valid;

  assign arb.req_ready        = (state_q == IDLE && win_valid) ? (4'b0001 << win_id) : 4'b0000;
  assign arb.req_dp_valid     = (in_resp && (arb.bus_dp_valid || resp_tmo)) ? (4'b0001 << grant_id_q) : 4'b0000;
  assign arb.req_dp_read_data = (in_resp && !resp_tmo) ? arb.bus_dp_read_data : '0;
  assign arb.bus_dp_ready     = in_resp && !resp_tmo && arb.req_dp_ready[grant_id_q];

  assign arb.bus_valid   = bus_valid_q;
  assign arb.bus_address = bus_address_q;
  assign arb.bus_wr_en   = bus_wr_en_q;
  assign arb.bus_wr_data = bus_wr_data_q;
  assign arb.bus_wr_size = bus_wr_size_q;
  assign arb.grant_id    = grant_id_q;
  assign arb.busy        = (state_q != IDLE);
  assign arb.timeout_err = timeout_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 2'd1;
      grant_id_q    <= 2'd0;
      tcnt_q        <= 8'd0;
      timeout_err_q <= 1'b0;
      bus_valid_q   <= 1'b0;
      bus_wr_en_q   <= 1'b0;
      bus_address_q <= '0;
      bus_wr_data_q <= '0;
      bus_wr_size_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_valid) begin
            bus_address_q <= arb.req_address[win_id*ADDRW +: ADDRW];
            bus_wr_en_q   <= arb.req_wr_en[win_id];
            bus_wr_data_q <= arb.req_wr_data[win_id*DATAW +: DATAW];
            bus_wr_size_q <= arb.req_wr_size[win_id*SIZEW +: SIZEW];
            grant_id_q    <= win_id;
            bus_valid_q   <= 1'b1;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          if (arb.bus_ready) begin
            bus_valid_q <= 1'b0;
            tcnt_q      <= 8'd0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (resp_tmo) begin
            timeout_err_q <= 1'b1;
            if (arb.req_dp_ready[grant_id_q]) state_q <= IDLE;
          end else if (arb.bus_dp_valid && arb.req_dp_ready[grant_id_q]) begin
            state_q <= IDLE;
            if (grant_id_q != 2'd0) rr_ptr_q <= (grant_id_q == 2'd3) ? 2'd1 : grant_id_q + 2'd1;
          end else if (!arb.bus_dp_valid && tcnt_q != TOUT_C) begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: the driver pushes predicted grants, bus requests and responses; a negedge monitor pops and compares.
// Expected winners come from a small rotation model of the arbitration rules, not from the DUT.
module tb_mem_port_arbiter;
  localparam int DATAW = 32;
  localparam int ADDRW = 32;
  localparam int SIZEW = 4;
  localparam int TOUT  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATAW(DATAW), .ADDRW(ADDRW), .SIZEW(SIZEW)) arb_if ();

  mem_port_arbiter #(.DATAW(DATAW), .ADDRW(ADDRW), .SIZEW(SIZEW), .TOUT(TOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .arb  (arb_if)
  );

  typedef struct {
    logic [ADDRW-1:0] addr;
    logic             we;
    logic [DATAW-1:0] wd;
    logic [SIZEW-1:0] sz;
    int               id;
  } bus_exp_t;

  typedef struct {
    int               id;
    logic [DATAW-1:0] data;
  } resp_exp_t;

  int        grant_q[$];
  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  int   n_cmp = 0;
  int   n_err = 0;
  int   model_rr = 1;
  logic model_tmo = 1'b0;
  int   txn_no = 0;

  logic [ADDRW-1:0] addr_v[4];
  logic             we_v[4];
  logic [DATAW-1:0] wd_v[4];
  logic [SIZEW-1:0] sz_v[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_pick(input logic [3:0] rv);
    int order[3];
    if (rv[0]) return 0;
    order[0] = model_rr;
    order[1] = model_rr % 3 + 1;
    order[2] = (model_rr + 1) % 3 + 1;
    for (int k = 0; k < 3; k++) begin
      if (rv[order[k]]) return order[k];
    end
    return -1;
  endfunction

  task automatic rand_fields();
    for (int p = 0; p < 4; p++) begin
      addr_v[p] = $urandom;
      we_v[p]   = 1'($urandom_range(0, 1));
      wd_v[p]   = $urandom;
      sz_v[p]   = 4'($urandom_range(0, 15));
    end
  endtask

  task automatic apply_fields();
    for (int p = 0; p < 4; p++) begin
      arb_if.req_address[p*ADDRW +: ADDRW] = addr_v[p];
      arb_if.req_wr_en[p]                  = we_v[p];
      arb_if.req_wr_data[p*DATAW +: DATAW] = wd_v[p];
      arb_if.req_wr_size[p*SIZEW +: SIZEW] = sz_v[p];
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_valid"},   64'(arb_if.bus_valid), 0);
    chk({tag, "_bus_wr_en"},   64'(arb_if.bus_wr_en), 0);
    chk({tag, "_bus_address"}, 64'(arb_if.bus_address), 0);
    chk({tag, "_bus_wr_data"}, 64'(arb_if.bus_wr_data), 0);
    chk({tag, "_bus_wr_size"}, 64'(arb_if.bus_wr_size), 0);
    chk({tag, "_req_ready"},   64'(arb_if.req_ready), 0);
    chk({tag, "_req_dp_valid"},64'(arb_if.req_dp_valid), 0);
    chk({tag, "_bus_dp_ready"},64'(arb_if.bus_dp_ready), 0);
    chk({tag, "_grant_id"},    64'(arb_if.grant_id), 0);
    chk({tag, "_busy"},        64'(arb_if.busy), 0);
    chk({tag, "_timeout_err"}, 64'(arb_if.timeout_err), 0);
  endtask

  // resp_wait < 0 means the bus never answers, so the forced timeout response is expected.
  task automatic do_txn(input logic [3:0] rv, input int bus_wait, input int resp_wait,
                        input int stall, input logic [DATAW-1:0] rdata, input bit abort);
    int        w;
    bit        hs;
    bit        tmo;
    bus_exp_t  be_l;
    resp_exp_t re_l;
    w   = model_pick(rv);
    tmo = (resp_wait < 0);
    apply_fields();
    arb_if.req_valid = rv;
    be_l.addr = addr_v[w];
    be_l.we   = we_v[w];
    be_l.wd   = wd_v[w];
    be_l.sz   = sz_v[w];
    be_l.id   = w;
    re_l.id   = w;
    re_l.data = tmo ? '0 : rdata;
    grant_q.push_back(w);
    bus_q.push_back(be_l);
    resp_q.push_back(re_l);

    hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      #1;
      hs = (arb_if.req_ready != 4'b0);
      step();
    end
    if (!hs) begin
      chk("accept_wait_expired", 0, 1);
      arb_if.req_valid = 4'b0;
      return;
    end
    arb_if.req_valid = 4'b0;
    rand_fields();
    apply_fields();

    for (int i = 0; i < bus_wait; i++) begin
      #1;
      chk("issue_hold_valid", 64'(arb_if.bus_valid), 1);
      chk("issue_hold_addr", 64'(arb_if.bus_address), 64'(be_l.addr));
      step();
    end
    arb_if.bus_ready = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 10 && !hs; i++) begin
      #1;
      hs = arb_if.bus_valid;
      step();
    end
    arb_if.bus_ready = 1'b0;
    if (!hs) begin
      chk("bus_valid_wait_expired", 0, 1);
      return;
    end

    if (abort) begin
      step();
      step();
      reset = 1'b1;
      step();
      chk_all_zero("abort_reset");
      reset = 1'b0;
      resp_q.delete();
      model_rr  = 1;
      model_tmo = 1'b0;
      $display("txn %0d: port=%0d abandoned by reset", txn_no, w);
      txn_no++;
      return;
    end

    if (!tmo) begin
      for (int i = 0; i < resp_wait; i++) step();
      arb_if.bus_dp_valid     = 1'b1;
      arb_if.bus_dp_read_data = rdata;
    end
    arb_if.req_dp_ready[w] = 1'b0;
    for (int i = 0; i < stall; i++) begin
      #1;
      chk("stall_bus_dp_ready", 64'(arb_if.bus_dp_ready), 0);
      chk("stall_busy", 64'(arb_if.busy), 1);
      step();
    end
    arb_if.req_dp_ready = 4'hF;
    hs = 1'b0;
    for (int i = 0; i < 40 && !hs; i++) begin
      #1;
      hs = |(arb_if.req_dp_valid & arb_if.req_dp_ready);
      step();
    end
    arb_if.bus_dp_valid     = 1'b0;
    arb_if.bus_dp_read_data = $urandom;
    if (!hs) begin
      chk("response_wait_expired", 0, 1);
      return;
    end
    if (!tmo && w != 0) model_rr = (w == 3) ? 1 : w + 1;
    if (tmo) model_tmo = 1'b1;
    #1;
    chk("post_busy", 64'(arb_if.busy), 0);
    chk("post_grant_id", 64'(arb_if.grant_id), 64'(w));
    chk("post_timeout_err", 64'(arb_if.timeout_err), 64'(model_tmo));
    $display("txn %0d: req_valid=%b port=%0d addr=0x%08h we=%0b data=0x%08h timeout=%0b",
             txn_no, rv, w, be_l.addr, be_l.we, re_l.data, tmo);
    txn_no++;
  endtask

  bus_exp_t  mon_be;
  resp_exp_t mon_re;
  int        mon_g;

  always @(negedge clk) begin
    if (!reset) begin
      if (arb_if.req_ready != 4'b0) begin
        if (grant_q.size() == 0) chk("grant_unexpected", 64'(arb_if.req_ready), 0);
        else begin
          mon_g = grant_q.pop_front();
          chk("grant_onehot", 64'(arb_if.req_ready), 64'(4'b0001 << mon_g));
        end
      end
      if (arb_if.bus_valid && arb_if.bus_ready) begin
        if (bus_q.size() == 0) chk("bus_unexpected", 64'(arb_if.bus_valid), 0);
        else begin
          mon_be = bus_q.pop_front();
          chk("bus_address", 64'(arb_if.bus_address), 64'(mon_be.addr));
          chk("bus_wr_en", 64'(arb_if.bus_wr_en), 64'(mon_be.we));
          chk("bus_wr_data", 64'(arb_if.bus_wr_data), 64'(mon_be.wd));
          chk("bus_wr_size", 64'(arb_if.bus_wr_size), 64'(mon_be.sz));
          chk("bus_grant_id", 64'(arb_if.grant_id), 64'(mon_be.id));
        end
      end
      if (|(arb_if.req_dp_valid & arb_if.req_dp_ready)) begin
        if (resp_q.size() == 0) chk("resp_unexpected", 64'(arb_if.req_dp_valid), 0);
        else begin
          mon_re = resp_q.pop_front();
          chk("resp_port", 64'(arb_if.req_dp_valid), 64'(4'b0001 << mon_re.id));
          chk("resp_data", 64'(arb_if.req_dp_read_data), 64'(mon_re.data));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    arb_if.req_valid        = 4'b0;
    arb_if.req_dp_ready     = 4'hF;
    arb_if.bus_ready        = 1'b0;
    arb_if.bus_dp_valid     = 1'b0;
    arb_if.bus_dp_read_data = '0;
    rand_fields();
    apply_fields();
    reset = 1'b1;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    // Single read to rmem with a two-cycle response.
    rand_fields();
    addr_v[1] = 32'h0000_2000;
    we_v[1]   = 1'b0;
    do_txn(4'b0010, 0, 2, 0, 32'h1234_5678, 1'b0);

    // Round-robin among rmem/wmem/imem.
    for (int i = 0; i < 6; i++) begin
      rand_fields();
      do_txn(4'b1110, 0, 0, 0, $urandom, 1'b0);
    end

    // emem priority, then rotation resumes.
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      do_txn(4'b1111, 0, 0, 0, $urandom, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      do_txn(4'b1110, 0, 0, 0, $urandom, 1'b0);
    end

    // Backpressure on both bus request and requester response.
    rand_fields();
    do_txn(4'b1000, 5, 0, 3, $urandom, 1'b0);

    // Bus response lands exactly on the timeout cycle, and one cycle before it.
    rand_fields();
    do_txn(4'b0100, 0, TOUT, 0, $urandom, 1'b0);
    rand_fields();
    do_txn(4'b0010, 0, TOUT - 1, 1, $urandom, 1'b0);

    // Silent bus: forced zero response and sticky error.
    rand_fields();
    do_txn(4'b0010, 0, -1, 0, $urandom, 1'b0);
    rand_fields();
    do_txn(4'b1110, 1, 1, 0, $urandom, 1'b0);

    // Reset in the middle of a response wait, then the pointer restarts at rmem.
    rand_fields();
    do_txn(4'b0100, 0, 0, 0, $urandom, 1'b1);
    rand_fields();
    do_txn(4'b1110, 0, 0, 0, $urandom, 1'b0);

    for (int i = 0; i < 60; i++) begin
      rand_fields();
      r = $urandom_range(0, 19);
      do_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3),
             (r == 0) ? -1 : $urandom_range(0, 4), $urandom_range(0, 2), $urandom, 1'b0);
    end

    repeat (4) step();
    chk("grant_queue_drained", 64'(grant_q.size()), 0);
    chk("bus_queue_drained", 64'(bus_q.size()), 0);
    chk("resp_queue_drained", 64'(resp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single main-memory bus between four pipeline memory ports: emem (interrupt/exception vector fetch), rmem (data read), wmem (data write) and imem (instruction fetch).
It sits between top_pipeline's memory interfaces and memory_subsystem_top's bus side.
It allows one outstanding transaction at a time: grant, issue, then wait for the response.
emem has fixed top priority; rmem, wmem and imem rotate round-robin.

Parameters:
DATAW, 32, data width of write data and read data.
ADDRW, 32, address width.
SIZEW, 4, width of the write-size field.
TOUT, 255, maximum cycles to wait for bus_dp_valid before the response is forced (8-bit counter).

Ports:
clk  in  1  system clock, all state on posedge.
reset  in  1  synchronous, active-high reset.
req_valid  in  4  request valid; bit0 emem, bit1 rmem, bit2 wmem, bit3 imem.
req_ready  out  4  one-hot accept for the granted requester.
req_address  in  4*ADDRW  per-port address; port i occupies [i*ADDRW +: ADDRW].
req_wr_en  in  4  per-port write enable.
req_wr_data  in  4*DATAW  per-port write data.
req_wr_size  in  4*SIZEW  per-port write size.
req_dp_valid  out  4  response valid, asserted only on the granted bit.
req_dp_ready  in  4  per-port response ready.
req_dp_read_data  out  DATAW  response data, broadcast to all ports.
bus_valid  out  1  bus request valid.
bus_ready  in  1  bus accepts the request.
bus_address  out  ADDRW  registered request address.
bus_wr_en  out  1  registered write enable.
bus_wr_data  out  DATAW  registered write data.
bus_wr_size  out  SIZEW  registered write size.
bus_dp_valid  in  1  bus response valid (read data, or write acknowledge).
bus_dp_ready  out  1  bus response ready.
bus_dp_read_data  in  DATAW  bus response data.
grant_id  out  2  index of the current or last granted port.
busy  out  1  high whenever state is not IDLE.
timeout_err  out  1  sticky flag, set on a response timeout.

Behaviour:
- Reset: state=IDLE, rr_ptr=1. All outputs 0: bus_valid, bus_wr_en, bus_address, bus_wr_data, bus_wr_size, req_ready, req_dp_valid, bus_dp_ready, grant_id, busy, timeout_err. Reset mid-transaction abandons it immediately; no response is returned.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - Winner selection: emem if req_valid[0]; otherwise the first set bit among {1,2,3} searched from rr_ptr upward, wrapping 3->1.
  - req_ready[w] is combinational in IDLE only.
  - On that edge: capture address, wr_en, wr_data and wr_size of port w; grant_id<=w; go to ISSUE.
  - No valid request: stay in IDLE.
- ISSUE:
  - bus_valid=1 with the captured fields, held stable until bus_ready.
  - On bus_valid&&bus_ready: bus_valid<=0, clear the timeout counter, go to RESP.
- RESP:
  - bus_dp_ready = req_dp_ready[grant_id].
  - req_dp_valid[grant_id] = bus_dp_valid; req_dp_read_data = bus_dp_read_data.
  - On bus_dp_valid&&bus_dp_ready: go to IDLE. If grant_id!=0, rr_ptr<=grant_id==3 ? 1 : grant_id+1. An emem grant leaves rr_ptr unchanged.
- Timeout:
  - An 8-bit counter increments each RESP cycle while bus_dp_valid=0.
  - When the count reaches TOUT: req_dp_valid[grant_id]=1 with data 0 for one handshake, timeout_err<=1 (sticky until reset), bus_dp_ready=0.
  - On req_dp_ready: go to IDLE.
  - A bus_dp_valid arriving in the same cycle as the timeout wins; no error is flagged.
- Latency:
  - Request accept at cycle N; bus_valid at N+1.
  - Bus response passes to the requester in the same cycle (combinational).
  - A new grant is possible the cycle after response completion, so minimum occupancy is 3 cycles per transaction.
- Requesters may change or drop req_valid at any time before acceptance; only the accept-cycle values are captured.
- Writes also wait for bus_dp_valid as the acknowledge; read data is don't-care for writes.

Test Plan:
1. Single read: req_valid=4'b0010, address 0x00002000; bus_ready=1 immediately; bus_dp_valid with 0x12345678 two cycles later.
   -> req_ready[1] pulses once; bus_address=0x00002000, bus_wr_en=0; req_dp_valid[1] with 0x12345678; grant_id=1; rr_ptr=2; busy low afterwards.
2. Round-robin: req_valid=4'b1110 held, single-cycle responses.
   -> Grant order 1,2,3,1,2,3. No port is granted twice before the other two.
3. emem priority: req_valid=4'b1111 held.
   -> emem is granted first and again on every IDLE while bit0 stays asserted. Clear bit0 -> order resumes 1,2,3.
4. Backpressure:
   - bus_ready=0 for 5 cycles -> bus_valid and bus_address stable throughout.
   - req_dp_ready[3]=0 for 3 cycles during a valid response -> bus_dp_ready=0 and state remains RESP.
5. Timeout: TOUT=8; bus never asserts bus_dp_valid after accepting a read.
   -> After 8 RESP cycles, req_dp_valid with data 0x0; timeout_err=1 and stays 1; next request grants normally.
6. Reset mid-transaction: reset=1 during RESP.
   -> Next cycle all outputs are 0, state IDLE; the first grant after reset follows the reset rr_ptr=1 rule.
